// File: rtl/mux3_rr_arbiter.sv
// mux3_rr_arbiter: round-robin owner selection for a shared 3:1 mux with a
// packet-locked grant and a one-entry registered output channel.
//
// Handshake: a beat moves into the output register on a cycle where the owner
// requests and the register is empty or being drained (!valid_o || ready_i);
// downstream takes the registered beat on any cycle with valid_o && ready_i.
// state_dbg_o / ptr_dbg_o expose the FSM state and round-robin pointer.
module mux3_rr_arbiter #(
    parameter int SIZE = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [2:0]      req_i,
    input  logic [2:0]      last_i,
    input  logic [SIZE-1:0] data0_i,
    input  logic [SIZE-1:0] data1_i,
    input  logic [SIZE-1:0] data2_i,
    output logic [2:0]      gnt_o,
    output logic [1:0]      select_o,
    output logic            valid_o,
    output logic [SIZE-1:0] data_o,
    output logic            last_o,
    input  logic            ready_i,
    output logic            state_dbg_o,
    output logic [1:0]      ptr_dbg_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      ptr_q, ptr_d;
    logic            valid_q, valid_d;
    logic [SIZE-1:0] data_q, data_d;
    logic            last_q, last_d;

    logic [1:0]      winner;
    logic            own_req;
    logic            own_last;
    logic [SIZE-1:0] own_data;
    logic            accept;

    // Round-robin pick: first requester at or after ptr, wrapping mod 3.
    always_comb begin
        winner = 2'd0;
        case (ptr_q)
            2'd1: begin
                if (req_i[1])      winner = 2'd1;
                else if (req_i[2]) winner = 2'd2;
                else               winner = 2'd0;
            end
            2'd2: begin
                if (req_i[2])      winner = 2'd2;
                else if (req_i[0]) winner = 2'd0;
                else               winner = 2'd1;
            end
            default: begin
                if (req_i[0])      winner = 2'd0;
                else if (req_i[1]) winner = 2'd1;
                else               winner = 2'd2;
            end
        endcase
    end

    // Shared 3:1 datapath mux steered by the current owner.
    always_comb begin
        own_req  = req_i[0];
        own_last = last_i[0];
        own_data = data0_i;
        case (owner_q)
            2'd1: begin
                own_req  = req_i[1];
                own_last = last_i[1];
                own_data = data1_i;
            end
            2'd2: begin
                own_req  = req_i[2];
                own_last = last_i[2];
                own_data = data2_i;
            end
            default: begin
                own_req  = req_i[0];
                own_last = last_i[0];
                own_data = data0_i;
            end
        endcase
    end

    assign accept = (state_q == BUSY) && own_req && (!valid_q || ready_i);

    // Grant pulse and select; both forced to zero while reset is asserted.
    always_comb begin
        gnt_o    = 3'b000;
        select_o = 2'd0;
        if (rst_i) begin
            select_o = owner_q;
            if (accept) begin
                case (owner_q)
                    2'd1:    gnt_o = 3'b010;
                    2'd2:    gnt_o = 3'b100;
                    default: gnt_o = 3'b001;
                endcase
            end
        end
    end

    // Next-state: arbitration in IDLE, beat transfer and packet end in BUSY,
    // output register drain independent of state.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req_i != 3'b000) begin
                    owner_d = winner;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && own_last) begin
                    state_d = IDLE;
                    ptr_d   = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            valid_d = 1'b1;
            data_d  = own_data;
            last_d  = own_last;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State and registered outputs; synchronous active-low reset drops any
    // partial packet and pending output beat.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign last_o      = last_q;
    assign state_dbg_o = state_q;
    assign ptr_dbg_o   = ptr_q;

endmodule

// File: doc/mux3_rr_arbiter.md
# mux3_rr_arbiter

Round-robin arbiter and sequencer that shares one 3:1 datapath multiplexer among three requesters and drives a single registered output channel. It computes the 2-bit mux select, locks the grant for a whole multi-beat packet, and hands each accepted beat to a one-entry output register with a valid/ready handshake. It sits in front of a shared resource such as a memory or write-back port, replacing a fixed-priority select.

## Interface
- size, 32, data width of each requester and of the output
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-low reset
- req_i  in  3  bit k: requester k has a beat presented on datak_i
- last_i  in  3  bit k: the beat on datak_i ends requester k's packet
- data0_i, data1_i, data2_i  in  size  beat payloads; each held stable until the matching gnt_o bit pulses
- gnt_o  out  3  one-hot, combinational pulse; bit k = requester k's beat accepted this cycle
- select_o  out  2  current owner: 0, 1 or 2; value 3 is never driven
- valid_o  out  1  data_o/last_o hold a beat
- data_o  out  size  registered beat payload
- last_o  out  1  registered last flag of the beat in data_o
- ready_i  in  1  downstream consumes the beat in data_o on a cycle where valid_o && ready_i

## Operation
- Registers: state (IDLE/BUSY), owner[1:0], ptr[1:0] (round-robin priority), valid_o, data_o, last_o.
- IDLE: if req_i != 0, pick the first set bit in the order ptr, ptr+1, ptr+2 (mod 3). Then owner <= winner and state <= BUSY. No beat is accepted in IDLE.
- BUSY: select_o = owner, and the mux output is the data of the owner.
- accept = BUSY && req_i[owner] && (!valid_o || ready_i).
- When accept is high:
  - gnt_o[owner] = 1
  - data_o <= data of owner
  - last_o <= last_i[owner]
  - valid_o <= 1
- Accept with last_i[owner] = 1: state <= IDLE and ptr <= (owner+1) mod 3.
- Not accept, with valid_o && ready_i: valid_o <= 0; data_o and last_o hold.
- The grant is locked for the full packet:
  - Requests from other requesters are ignored while BUSY.
  - If the owner drops req_i mid-packet, the block stalls in BUSY with no timeout.
- ptr and owner change only as stated above. select_o holds the last owner while IDLE.
- Reset (rst_i = 0 at an edge): state = IDLE, owner = 0, ptr = 0, valid_o = 0, data_o = 0, last_o = 0.
  - gnt_o = 0 and select_o = 0 during the reset cycle.
  - A partial packet or a pending output beat is discarded.

## Timing
- Arbitration latency: requester wins at edge N (IDLE→BUSY). Its first beat can be accepted in cycle N+1, and valid_o is high after edge N+1.
- Throughput inside a packet: 1 beat per cycle while ready_i = 1 (consume and accept in the same cycle).
- Packet turnaround: 1 idle arbitration cycle between packets. valid_o may stay high across that cycle while the last beat is unconsumed.
- Backpressure: if valid_o && !ready_i, accept = 0, gnt_o = 0, and the output register holds.
- gnt_o and select_o are combinational from registered state and req_i. There is no combinational path from data*_i to data_o.
- Single-beat packet (last_i set on the first beat): BUSY lasts exactly one accept cycle.

## Test plan
- Reset, then all req_i = 0 → valid_o = 0, gnt_o = 0, select_o = 0 and state IDLE for 10 cycles. Assert rst_i low mid-packet → next cycle valid_o = 0, ptr = 0.
- req_i = 3'b111, every beat last, ready_i = 1 → grant order 0,1,2,0,1,2. Each gnt pulse lands 1 cycle after arbitration. data_o shows data0/1/2 values (e.g. 0xA0, 0xB1, 0xC2) in that order.
- Requester 1 sends a 4-beat packet (last on beat 4) while req0 and req2 are held high → four consecutive gnt_o = 3'b010. select_o = 1 throughout. Requester 2 is granted next.
- ready_i = 0 for 5 cycles mid-packet → valid_o stays 1, data_o is unchanged, gnt_o = 0. After ready_i returns to 1, beats resume at 1 per cycle with no loss or duplication.
- Owner drops req_i for 3 cycles mid-packet while the others request → no grants, select_o unchanged. The packet then completes before any other grant.
- Only req_i = 3'b100 with ptr = 0 → requester 2 is granted. After its last beat, ptr = 0.
